// File: rtl/sdram_arbiter_if.sv
// Handshake bundle between the two requesters, the arbiter and the SDRAM controller.
//   req0_* / req1_* : requester ports (addr, data, we, start in; q, done out)
//   grant / busy    : arbitration status
//   sdc_*           : 1:1 connection to the SDRAM controller
// Modports: slave = arbiter view, master = requester/controller side view.
interface sdram_arbiter_if #(
    parameter int unsigned ADDR_W = 24,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LINE_W = 256
);
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_we;
    logic              req0_start;
    logic [LINE_W-1:0] req0_q;
    logic              req0_done;

    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_we;
    logic              req1_start;
    logic [LINE_W-1:0] req1_q;
    logic              req1_done;

    logic              grant;
    logic              busy;

    logic [ADDR_W-1:0] sdc_addr;
    logic [DATA_W-1:0] sdc_data;
    logic              sdc_we;
    logic              sdc_start;
    logic [LINE_W-1:0] sdc_q;
    logic              sdc_ack;
    logic              sdc_busy;

    modport slave (
        input  req0_addr, req0_data, req0_we, req0_start,
        output req0_q, req0_done,
        input  req1_addr, req1_data, req1_we, req1_start,
        output req1_q, req1_done,
        output grant, busy,
        output sdc_addr, sdc_data, sdc_we, sdc_start,
        input  sdc_q, sdc_ack, sdc_busy
    );

    modport master (
        output req0_addr, req0_data, req0_we, req0_start,
        input  req0_q, req0_done,
        output req1_addr, req1_data, req1_we, req1_start,
        input  req1_q, req1_done,
        input  grant, busy,
        input  sdc_addr, sdc_data, sdc_we, sdc_start,
        output sdc_q, sdc_ack, sdc_busy
    );
endinterface

// File: rtl/sdram_arbiter.sv
// Two-port arbiter sharing one SDRAM controller between two requesters.
// Latches the winning request, runs the controller start/ack/busy handshake,
// then returns the read line (or write completion) to the granted port with a
// one-cycle done pulse.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : sdram_arbiter_if.slave (requester ports, grant/busy, sdc_* controller port)
// FIXED_PRIO = 0 selects round-robin on ties, 1 makes port 0 win every tie.
module sdram_arbiter #(
    parameter int unsigned ADDR_W     = 24,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LINE_W     = 256,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    sdram_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    logic              last_grant;

    logic              pick_c;
    logic [ADDR_W-1:0] addr_c;
    logic [DATA_W-1:0] data_c;
    logic              we_c;
    logic [LINE_W-1:0] line_c;

    // Winner selection and request mux used at the grant edge.
    always_comb begin
        pick_c = bus.req1_start;
        if (bus.req0_start && bus.req1_start) begin
            pick_c = FIXED_PRIO ? 1'b0 : ~last_grant;
        end
        addr_c = pick_c ? bus.req1_addr : bus.req0_addr;
        data_c = pick_c ? bus.req1_data : bus.req0_data;
        we_c   = pick_c ? bus.req1_we   : bus.req0_we;
        line_c = bus.sdc_q;
    end

    // Arbitration and controller handshake FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            bus.grant     <= 1'b0;
            bus.busy      <= 1'b0;
            bus.sdc_addr  <= '0;
            bus.sdc_data  <= '0;
            bus.sdc_we    <= 1'b0;
            bus.sdc_start <= 1'b0;
            bus.req0_q    <= '0;
            bus.req1_q    <= '0;
            bus.req0_done <= 1'b0;
            bus.req1_done <= 1'b0;
        end else begin
            bus.req0_done <= 1'b0;
            bus.req1_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.req0_start || bus.req1_start) begin
                        bus.sdc_addr  <= addr_c;
                        bus.sdc_data  <= data_c;
                        bus.sdc_we    <= we_c;
                        bus.grant     <= pick_c;
                        last_grant    <= pick_c;
                        bus.busy      <= 1'b1;
                        bus.sdc_start <= 1'b1;
                        state         <= REQ;
                    end
                end

                // Request stays latched and start stays high until the controller acks.
                REQ: begin
                    if (bus.sdc_ack) begin
                        bus.sdc_start <= 1'b0;
                        state         <= WAIT;
                    end
                end

                // Controller holds busy from the ack cycle; first low busy means the line is valid.
                WAIT: begin
                    if (!bus.sdc_busy) begin
                        if (bus.grant) begin
                            if (!bus.sdc_we) bus.req1_q <= line_c;
                            bus.req1_done <= 1'b1;
                        end else begin
                            if (!bus.sdc_we) bus.req0_q <= line_c;
                            bus.req0_done <= 1'b1;
                        end
                        state <= DONE;
                    end
                end

                // Done pulse cycle; requests are not looked at here.
                DONE: begin
                    bus.busy   <= 1'b0;
                    bus.sdc_we <= 1'b0;
                    state      <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
Two-port arbiter that shares the single SDRAM controller between two requesters, for example the instruction cache (port 0) and the data cache/DMA (port 1).
It latches the winning request and drives the controller's start/ack/busy handshake. It then returns the 256-bit cache line, or write completion, to the granted port with a one-cycle done pulse.
It sits between the cache/bus layer and the SDRAM controller. The controller's ports connect 1:1 to the sdc_* ports below.

Parameters:
ADDR_W, 24, request/controller address width
DATA_W, 32, write data width
LINE_W, 256, read line width (controller sdc_q)
FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins on simultaneous requests

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
req0_addr  in  ADDR_W  port 0 address
req0_data  in  DATA_W  port 0 write data
req0_we  in  1  port 0 write enable (1 = write, 0 = line read)
req0_start  in  1  port 0 request; level, held until req0_done
req0_q  out  LINE_W  port 0 read line, registered
req0_done  out  1  port 0 one-cycle completion pulse
req1_addr / req1_data / req1_we / req1_start / req1_q / req1_done  same as port 0, for port 1
grant  out  1  index of port owning the controller (valid while busy=1)
busy  out  1  arbiter not in IDLE
sdc_addr  out  ADDR_W  to controller
sdc_data  out  DATA_W  to controller
sdc_we  out  1  to controller
sdc_start  out  1  to controller start trigger
sdc_q  in  LINE_W  controller line output
sdc_ack  in  1  controller start acknowledge (one-cycle pulse)
sdc_busy  in  1  controller busy status

Behaviour:
- Reset: state = IDLE. All of these are 0: sdc_start, sdc_we, sdc_addr, sdc_data, req0_done, req1_done, req0_q, req1_q, grant, busy. last_grant = 1, so port 0 wins the first tie. Reset mid-transaction aborts immediately to IDLE; no done pulse is issued.
- Controller contract: sdc_busy is asserted no later than the cycle sdc_ack is high. sdc_q is valid in every cycle where sdc_busy = 0 after an ack.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If no reqN_start is high, stay in IDLE.
  - If exactly one reqN_start is high, grant that port.
  - If both are high: with FIXED_PRIO=0, grant the port != last_grant; with FIXED_PRIO=1, grant port 0.
  - On grant, at the same edge: register that port's addr/data/we into sdc_addr/sdc_data/sdc_we; set grant and last_grant; busy = 1; sdc_start = 1; go to REQ.
- REQ:
  - sdc_start held at 1 and sdc_addr/data/we held stable until sdc_ack = 1.
  - On ack: sdc_start = 0 at that edge; go to WAIT.
  - There is no timeout; REQ waits indefinitely.
- WAIT: sdc_busy is sampled starting the cycle after ack. On the first sdc_busy = 0:
  - For a read (sdc_we = 0), capture sdc_q into reqG_q.
  - Set reqG_done = 1; go to DONE.
- DONE:
  - reqG_done is high for exactly this one cycle.
  - The next state is always IDLE. reqN_start is ignored in DONE.
  - busy = 0 and sdc_we = 0 on the exit edge.
  - sdc_addr/sdc_data keep their last values (don't-care to the controller).
- Writes: reqG_q is not modified; done is still pulsed.
- The non-granted port's q and done are never disturbed.
- Request inputs are sampled only at the grant edge. Changes to addr/data/we/start after grant are ignored, and the transaction completes even if start drops.
- Minimum latency, start seen in IDLE at cycle 0:
  - sdc_start visible at cycle 1.
  - With ack in cycle 1 and busy low in cycle 2, done is high in cycle 3.
  - The next grant is possible from IDLE at cycle 4.
- The same port re-requesting with start still high in IDLE is a new request. Under round-robin it loses to the other port if both are requesting.
- Round-robin fairness: with both ports continuously requesting, grants alternate 0,1,0,1,...

Test Plan:
- Single read, port 0: after reset, req0_start=1, addr=24'h000100, we=0. Mock controller acks 2 cycles after start and drops busy 10 cycles later with sdc_q = 256'hA5…A5 -> sdc_addr=24'h000100 while sdc_start=1; req0_q=256'hA5…A5; req0_done high exactly 1 cycle; req1_done never asserts.
- Single write, port 1: addr=24'h00FFFF, data=32'hDEADBEEF, we=1 -> sdc_we=1, sdc_data=32'hDEADBEEF held until ack; req1_done pulses once; req1_q stays 0.
- Simultaneous requests, FIXED_PRIO=0, both held for 6 transactions -> grant sequence 0,1,0,1,0,1. FIXED_PRIO=1 with port 0 re-asserting after each done -> port 0 wins every tie.
- Slow ack: mock controller withholds ack for 20 cycles while req0 changes addr to 24'h123456 -> sdc_start stays 1 for 20 cycles; sdc_addr keeps the originally latched address; exactly one transaction occurs.
- Reset asserted while in WAIT -> next cycle: sdc_start=0, busy=0, no done pulse. A fresh request afterwards is granted port 0 first.
- Minimum latency: mock controller acks in the same cycle as sdc_start and drops busy the next cycle -> done is high 3 cycles after start is sampled, and busy returns to 0 the following cycle.
